// File: rtl/nios_pio_pkg.sv
// Shared constants and helpers for the Nios input PIO.
// Register offsets, settle length, clog2.
package nios_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd1;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd2;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd3;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd4;

  localparam int SETTLE_CYCLES = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/nios_security_pio_in_edge_if.sv
// Avalon-MM slave bus bundle for the input PIO.
// The master drives address/strobes, the slave returns readdata.
interface nios_security_pio_in_edge_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write, writedata,
    output readdata
  );

endinterface

// File: rtl/nios_pio_debounce_bit.sv
// One input bit: 2-flop synchroniser plus stable-count debounce.
// next_deb is exposed so the top can see an edge before it lands.
module nios_pio_debounce_bit
  import nios_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic armed,
  input  logic din,
  output logic deb,
  output logic next_deb
);

  localparam int CWR = clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW  = (CWR < 1) ? 1 : CWR;
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // While settling, follow the input; once armed, require a stable run.
  always_comb begin
    next_deb = deb;
    cnt_nxt  = '0;
    if (!armed) begin
      next_deb = sync2;
    end else if (sync2 != deb) begin
      if (DEBOUNCE_CYCLES == 0 || cnt == LIMIT) begin
        next_deb = sync2;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // Synchroniser, counter and debounced value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      deb   <= next_deb;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: rtl/nios_security_pio_in_edge.sv
// Avalon-MM input PIO with debounce, edge capture (W1C) and
// a maskable level interrupt.
module nios_security_pio_in_edge
  import nios_pio_pkg::*;
#(
  parameter int               WIDTH           = 16,
  parameter int               DEBOUNCE_CYCLES = 0,
  parameter logic [WIDTH-1:0] RESET_RISE_EN   = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  nios_security_pio_in_edge_if.slave  bus,
  input  logic [WIDTH-1:0]            in_port,
  output logic                        irq
);

  localparam int SW = clog2(SETTLE_CYCLES + 1);

  logic [SW-1:0]    settle_cnt;
  logic             armed;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] next_deb;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] wdat;
  logic             wr_en;
  logic [31:0]      rd_nxt;
  logic             unused_wd;

  assign wr_en     = bus.chipselect & bus.write;
  assign wdat      = bus.writedata[WIDTH-1:0];
  assign unused_wd = ^bus.writedata;

  // Keep edges disarmed until the synchroniser carries live input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_cnt <= '0;
      armed      <= 1'b0;
    end else if (!armed) begin
      settle_cnt <= settle_cnt + 1'b1;
      if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
        armed <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nios_pio_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk      (clk),
      .reset    (reset),
      .armed    (armed),
      .din      (in_port[i]),
      .deb      (deb[i]),
      .next_deb (next_deb[i])
    );
  end

  // Enabled edges seen this cycle and the W1C clear mask.
  always_comb begin
    rise = {WIDTH{armed}} & ~deb & next_deb & rise_en;
    fall = {WIDTH{armed}} & deb & ~next_deb & fall_en;
    clr  = '0;
    if (wr_en && bus.address == ADDR_EDGE_CAP) begin
      clr = wdat;
    end
  end

  // Control registers; a new edge beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_en  <= RESET_RISE_EN;
      fall_en  <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      edge_cap <= (edge_cap & ~clr) | rise | fall;
      if (wr_en && bus.address == ADDR_RISE_EN) begin
        rise_en <= wdat;
      end
      if (wr_en && bus.address == ADDR_FALL_EN) begin
        fall_en <= wdat;
      end
      if (wr_en && bus.address == ADDR_IRQ_MASK) begin
        irq_mask <= wdat;
      end
    end
  end

  // Zero-extended read mux; unmapped offsets read 0.
  always_comb begin
    rd_nxt = '0;
    unique case (1'b1)
      (bus.address == ADDR_DATA):     rd_nxt[WIDTH-1:0] = deb;
      (bus.address == ADDR_RISE_EN):  rd_nxt[WIDTH-1:0] = rise_en;
      (bus.address == ADDR_FALL_EN):  rd_nxt[WIDTH-1:0] = fall_en;
      (bus.address == ADDR_IRQ_MASK): rd_nxt[WIDTH-1:0] = irq_mask;
      (bus.address == ADDR_EDGE_CAP): rd_nxt[WIDTH-1:0] = edge_cap;
      default:                        rd_nxt = '0;
    endcase
  end

  // Registered read data and level interrupt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.readdata <= '0;
      irq          <= 1'b0;
    end else begin
      bus.readdata <= rd_nxt;
      irq          <= |(edge_cap & irq_mask);
    end
  end

endmodule

// File: doc/nios_security_pio_in_edge.md
Name: nios_security_pio_in_edge

Overview:
Parametrised Avalon-MM input PIO slave for the Nios subsystem. It is the successor to the fixed 16-bit read-only input port. It adds:
- a 2-flop input synchroniser;
- per-bit debounce;
- per-bit rising/falling edge capture with write-1-to-clear;
- a maskable level interrupt to the CPU.

Typical use: sensor data-ready lines and UART/IMU status pins.

Parameters:
- WIDTH, 16, number of input bits, 1..32.
- DEBOUNCE_CYCLES, 0, consecutive stable cycles needed before the debounced value changes. 0 = no filtering. Range 0..65535.
- RESET_RISE_EN, 0, reset value of the rise-enable register, WIDTH bits.

Ports:
- clk  in  1  system clock. One clock domain only.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  word offset.
- chipselect  in  1  slave select.
- write  in  1  write strobe, qualified by chipselect.
- writedata  in  32  write data. Bits [WIDTH-1:0] are used.
- readdata  out  32  registered read data, latency 1.
- in_port  in  WIDTH  asynchronous external inputs.
- irq  out  1  registered level interrupt.

Behaviour:
- Register map (read and write use the same offsets):
  - 0 DATA: RO, debounced value.
  - 1 RISE_EN: RW.
  - 2 FALL_EN: RW.
  - 3 IRQ_MASK: RW.
  - 4 EDGE_CAP: read, plus write-1-to-clear.
  - 5..7: read 0, writes ignored.
- All reads are zero-extended above WIDTH.
- readdata is registered every clk from address, independent of read/chipselect. Value appears on the edge after address is presented.
- Reset (asynchronous, while reset=1) clears to 0: sync1, sync2, deb, debounce counters, FALL_EN, IRQ_MASK, EDGE_CAP, readdata, irq, settle counter and armed. RISE_EN resets to RESET_RISE_EN.
- Synchroniser: sync1 <= in_port, sync2 <= sync1.
- Settling: for the first 3 clk edges after reset deasserts, armed=0.
  - deb <= sync2 directly; counters are held at 0; no edges are captured.
  - armed=1 from the 4th edge onward.
  - Consequence: no spurious edge for inputs already high at reset.
- Debounce, per bit, when armed:
  - If sync2==deb, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES (or DEBOUNCE_CYCLES==0), deb <= sync2 and cnt <= 0.
  - Else cnt++.
  - Counter width is clog2(DEBOUNCE_CYCLES+1). It never wraps.
- Latency: in_port sampled into sync1 at edge t0 → deb updated at edge t0+2+DEBOUNCE_CYCLES → visible on readdata one edge after that (if address=0).
- Edge capture, per bit:
  - rise = armed & ~deb & next_deb & RISE_EN.
  - fall = armed & deb & ~next_deb & FALL_EN.
  - EDGE_CAP[i] is set on the same edge deb changes.
- W1C: chipselect & write & address==4 clears the bits where writedata=1.
  - If a new edge and a clear hit the same bit in the same cycle, the bit stays 1 (set wins).
- Enables: changing RISE_EN/FALL_EN does not clear EDGE_CAP. Disabled edges are not captured and never set EDGE_CAP.
- irq <= |(EDGE_CAP & IRQ_MASK), registered, one cycle after EDGE_CAP or IRQ_MASK changes. irq stays high until cleared; it is a level, not a pulse.
- Reset mid-debounce discards the pending change and re-enters settling.

Decomposition:
- Package nios_pio_pkg:
  - address constants ADDR_DATA=0, ADDR_RISE_EN=1, ADDR_FALL_EN=2, ADDR_IRQ_MASK=3, ADDR_EDGE_CAP=4;
  - SETTLE_CYCLES=3;
  - a clog2 function.
- Sub-module nios_pio_debounce_bit:
  - contains sync1/sync2, counter and deb for one bit;
  - outputs deb and next_deb;
  - generated WIDTH times.
- Top level holds the registers, capture logic, irq and read mux.

Test Plan:
- Reset with in_port=16'h00FF held high, default params → after 4 edges: read addr0 = 0x000000FF, EDGE_CAP=0, irq=0.
- Rising edge, D=0:
  - write RISE_EN=0x0001, IRQ_MASK=0x0001;
  - raise in_port[0] at t0 → DATA bit0 =1 at t0+2, EDGE_CAP=0x1 at t0+2, irq=1 at t0+3.
  - Write 0x1 to addr4 → EDGE_CAP=0, irq=0 one cycle later.
- Debounce, D=4:
  - 3-cycle high glitch on bit3 → DATA and EDGE_CAP unchanged.
  - High held 10 cycles → deb rises at t0+6.
- Simultaneous: W1C to bit2 on the same edge a falling edge on bit2 is captured (FALL_EN=0x4) → EDGE_CAP bit2 remains 1.
- Mask and map checks:
  - EDGE_CAP=0x8 with IRQ_MASK=0 → irq=0;
  - set IRQ_MASK=0x8 → irq=1 next cycle;
  - reads of addr5..7 return 0; writes to addr0 have no effect.
- Reset asserted mid-debounce (D=4, 2 cycles into a change) → all registers 0, no edge is captured after release.
